sram_arbiter: RTL and testbench

Two-client arbiter and sequencer placed in front of sram_control. Accepts single-word read/write requests from two independent requesters and grants access round-robin. Drives sram_control's write/read command pulses, address and data, then waits a fixed, parameterised latency before returning read data and an acknowledge to the granted client. Exactly one SRAM operation is in flight at any time.

---
 rtl/sram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// ============================================================================
// sram_arbiter : round-robin two-client front end for sram_control
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_arbiter #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int WR_LAT = 3,
  parameter int RD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] c_WR_LAT = 8'(WR_LAT);
  localparam logic [7:0] c_RD_LAT = 8'(RD_LAT);

  state_t              r_state;
  state_t              w_next;
  logic                r_last;
  logic                r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [7:0]          r_cnt;
  logic [DATA_W-1:0]   r_c0_rdata;
  logic [DATA_W-1:0]   r_c1_rdata;
  logic                w_any_req;
  logic                w_grant;
  logic                w_rd_done;

  // On a tie the client that was not served last wins.
  always_comb begin
    w_any_req = c0_req | c1_req;
    if (c0_req && c1_req) begin
      w_grant = ~r_last;
    end else begin
      w_grant = c1_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    c0_ack      = 1'b0;
    c1_ack      = 1'b0;
    w_rd_done   = 1'b0;
    busy        = (r_state != S_IDLE);
    owner       = r_owner;
    mem_address = r_addr;
    mem_data    = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_write = r_we;
        mem_read  = ~r_we;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 8'd1) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        c0_ack    = ~r_owner;
        c1_ack    = r_owner;
        w_rd_done = ~r_we;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Read data is visible in the ack cycle and held afterwards.
    c0_rdata = (w_rd_done && !r_owner) ? mem_rdata : r_c0_rdata;
    c1_rdata = (w_rd_done &&  r_owner) ? mem_rdata : r_c1_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= 8'd0;
      r_c0_rdata <= '0;
      r_c1_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_we    <= w_grant ? c1_we    : c0_we;
            r_addr  <= w_grant ? c1_addr  : c0_addr;
            r_wdata <= w_grant ? c1_wdata : c0_wdata;
          end
        end
        S_ISSUE: begin
          r_cnt <= r_we ? c_WR_LAT : c_RD_LAT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
        end
        S_DONE: begin
          r_last <= r_owner;
          if (!r_we) begin
            if (r_owner) begin
              r_c1_rdata <= mem_rdata;
            end else begin
              r_c0_rdata <= mem_rdata;
            end
          end
        end
        default: r_cnt <= 8'd0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// tb_sram_arbiter : directed, table-driven self-checking bench for sram_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sram_arbiter;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int WL = 3;
  localparam int RL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_req, c0_we, c0_ack;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata, c0_rdata;
  logic          c1_req, c1_we, c1_ack;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata, c1_rdata;
  logic          mem_write, mem_read, busy, owner;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          cl;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mrd;
    logic [DW-1:0] exp_c0_rd;
    logic [DW-1:0] exp_c1_rd;
  } vec_t;

  vec_t vecs[6];

  sram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WR_LAT(WL), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rdata(c1_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data(mem_data), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One isolated op; n counts cycles after the request-sampling edge.
  task automatic run_vec(input vec_t v);
    int lat;
    lat = v.we ? WL : RL;
    mem_rdata = v.mrd;
    if (v.cl) begin
      c1_req = 1'b1; c1_we = v.we; c1_addr = v.addr; c1_wdata = v.wdata;
    end else begin
      c0_req = 1'b1; c0_we = v.we; c0_addr = v.addr; c0_wdata = v.wdata;
    end
    for (int n = 1; n <= lat + 3; n++) begin
      step;
      chk1("mem_write", mem_write, (n == 1) && v.we);
      chk1("mem_read", mem_read, (n == 1) && !v.we);
      chk1("busy", busy, n <= lat + 2);
      chk1("owner", owner, v.cl);
      chk1("own_ack", v.cl ? c1_ack : c0_ack, n == lat + 2);
      chk1("other_ack", v.cl ? c0_ack : c1_ack, 1'b0);
      if (n <= lat + 2) begin
        chk4("mem_address", mem_address, v.addr);
        if (v.we) chk4("mem_data", mem_data, v.wdata);
      end
      if (n == 1) begin
        // Inputs changing after the grant must not disturb the latched op.
        if (v.cl) begin
          c1_we = ~v.we; c1_addr = ~v.addr; c1_wdata = ~v.wdata;
        end else begin
          c0_we = ~v.we; c0_addr = ~v.addr; c0_wdata = ~v.wdata;
        end
      end
      if (n == lat + 2) begin
        c0_req = 1'b0;
        c1_req = 1'b0;
      end
    end
    chk4("c0_rdata", c0_rdata, v.exp_c0_rd);
    chk4("c1_rdata", c1_rdata, v.exp_c1_rd);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    vecs[1] = '{1'b1, 1'b0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2};
    vecs[2] = '{1'b0, 1'b0, 4'h5, 4'h0, 4'h9, 4'h9, 4'h2};
    vecs[3] = '{1'b1, 1'b1, 4'h6, 4'h7, 4'hF, 4'h9, 4'h2};
    vecs[4] = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h3, 4'h9, 4'h2};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'hA, 4'h9, 4'hA};

    rst = 1'b1;
    c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk4("rst_c0_rdata", c0_rdata, 4'h0);
    chk4("rst_c1_rdata", c1_rdata, 4'h0);
    rst = 1'b0;
    step;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // A one-cycle c0 request while c1 is being served is lost.
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 4'h2; mem_rdata = 4'h8;
    for (int n = 1; n <= 12; n++) begin
      step;
      chk1("lost_c0_ack", c0_ack, 1'b0);
      chk1("lost_c1_ack", c1_ack, n == RL + 2);
      chk1("lost_busy", busy, n <= RL + 2);
      chk1("lost_mem_write", mem_write, 1'b0);
      if (n == 2) begin
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 4'h9;
      end
      if (n == 3) c0_req = 1'b0;
      if (n == RL + 2) c1_req = 1'b0;
    end
    chk4("lost_c1_rdata", c1_rdata, 4'h8);

    // Lone requester held high: served back to back every RL+3 cycles.
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 4'hB; mem_rdata = 4'h5;
    for (int n = 1; n <= 20; n++) begin
      step;
      chk1("b2b_mem_read", mem_read, n == 1 || n == 8 || n == 15);
      chk1("b2b_c1_ack", c1_ack, n == 6 || n == 13 || n == 20);
      chk1("b2b_c0_ack", c0_ack, 1'b0);
      chk1("b2b_owner", owner, 1'b1);
      if (n == 1)  chk4("b2b_addr0", mem_address, 4'hB);
      if (n == 8)  chk4("b2b_addr1", mem_address, 4'hC);
      if (n == 15) chk4("b2b_addr2", mem_address, 4'hD);
      if (n == 7)  chk4("b2b_rdata0", c1_rdata, 4'h5);
      if (n == 14) chk4("b2b_rdata1", c1_rdata, 4'h6);
      if (n == 6)  c1_addr = 4'hC;
      if (n == 13) c1_addr = 4'hD;
      if (n == 7)  mem_rdata = 4'h6;
      if (n == 14) mem_rdata = 4'h7;
      if (n == 20) c1_req = 1'b0;
    end
    step;
    chk1("b2b_idle", busy, 1'b0);
    chk4("b2b_rdata2", c1_rdata, 4'h7);

    // Asynchronous reset while in WAIT aborts the op.
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 4'h7;
    step; step; step;
    chk1("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_owner", owner, 1'b0);
    chk1("arst_ack", c0_ack, 1'b0);
    chk4("arst_mem_address", mem_address, 4'h0);
    chk4("arst_c0_rdata", c0_rdata, 4'h0);
    chk4("arst_c1_rdata", c1_rdata, 4'h0);
    c0_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step;
      chk1("post_rst_ack", c0_ack | c1_ack, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
    end

    // Continuous tie after reset: c0 first, then alternate.
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 4'h3; c0_wdata = 4'h3;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 4'h3; c1_wdata = 4'h0;
    mem_rdata = 4'h3;
    for (int n = 1; n <= 25; n++) begin
      step;
      chk1("tie_mem_write", mem_write, n == 1 || n == 14);
      chk1("tie_mem_read", mem_read, n == 7 || n == 20);
      chk1("tie_c0_ack", c0_ack, n == 5 || n == 18);
      chk1("tie_c1_ack", c1_ack, n == 12 || n == 25);
      chk1("tie_owner", owner, (n >= 7 && n <= 13) || n >= 20);
      if (n == 25) begin
        c0_req = 1'b0;
        c1_req = 1'b0;
      end
    end
    step;
    chk1("tie_idle", busy, 1'b0);
    chk4("tie_c1_rdata", c1_rdata, 4'h3);
    chk4("tie_c0_rdata", c0_rdata, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
